// File: rtl/fizzbuzz_core.sv
// fizzbuzz_core: single-stage registered divisibility classifier.
// Each accepted number yields its mod-3 and mod-5 residues plus fizz/buzz/
// fizzbuzz flags one clock later. Residues come from weighted bit sums
// (2^i mod m) folded back into range, so no divider is inferred.
//
// Handshake: a number is accepted on every rising edge where in_valid=1;
// there is no ready, so the source may stream one number per cycle.
// out_valid=1 means the result registers were loaded at the last edge; when
// out_valid=0 the result registers keep the last result.
module fizzbuzz_core #(
  parameter int WIDTH = 8  // legal range 2..32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] number,
  output logic             out_valid,
  output logic             fizz,
  output logic             buzz,
  output logic             fizzbuzz,
  output logic [1:0]       rem3,
  output logic [2:0]       rem5
);

  // Accumulators are 8 bits wide. Worst case at WIDTH=32: mod-3 sum is
  // 16*(1+2)=48, mod-5 sum is 8*(1+2+4+3)=80; both fit below 256.
  localparam int ACC_W = 8;

  // Weighted sum of number bits, weights 1,2,1,2,... (2^i mod 3).
  function automatic logic [ACC_W-1:0] num_wsum3(input logic [WIDTH-1:0] v);
    logic [ACC_W-1:0] s;
    s = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (v[i]) s = s + (i[0] ? 8'd2 : 8'd1);
    end
    return s;
  endfunction

  // Weighted sum of number bits, weights 1,2,4,3,... (2^i mod 5).
  function automatic logic [ACC_W-1:0] num_wsum5(input logic [WIDTH-1:0] v);
    logic [ACC_W-1:0] s;
    s = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (v[i]) begin
        case (i[1:0])
          2'd0:    s = s + 8'd1;
          2'd1:    s = s + 8'd2;
          2'd2:    s = s + 8'd4;
          default: s = s + 8'd3;
        endcase
      end
    end
    return s;
  endfunction

  // Same mod-3 weighting applied to an accumulator value.
  function automatic logic [ACC_W-1:0] acc_wsum3(input logic [ACC_W-1:0] v);
    logic [ACC_W-1:0] s;
    s = '0;
    for (int i = 0; i < ACC_W; i++) begin
      if (v[i]) s = s + (i[0] ? 8'd2 : 8'd1);
    end
    return s;
  endfunction

  // Same mod-5 weighting applied to an accumulator value.
  function automatic logic [ACC_W-1:0] acc_wsum5(input logic [ACC_W-1:0] v);
    logic [ACC_W-1:0] s;
    s = '0;
    for (int i = 0; i < ACC_W; i++) begin
      if (v[i]) begin
        case (i[1:0])
          2'd0:    s = s + 8'd1;
          2'd1:    s = s + 8'd2;
          2'd2:    s = s + 8'd4;
          default: s = s + 8'd3;
        endcase
      end
    end
    return s;
  endfunction

  // Fold a mod-3 accumulator to 0..2. Two weighting passes shrink any 8-bit
  // value to at most 6, then two conditional subtracts finish the job.
  function automatic logic [1:0] fold3(input logic [ACC_W-1:0] acc);
    logic [ACC_W-1:0] s;
    s = acc_wsum3(acc_wsum3(acc));
    if (s >= 8'd3) s = s - 8'd3;
    if (s >= 8'd3) s = s - 8'd3;
    return 2'(s);
  endfunction

  // Fold a mod-5 accumulator to 0..4. Two weighting passes shrink any 8-bit
  // value to at most 11, then two conditional subtracts finish the job.
  function automatic logic [2:0] fold5(input logic [ACC_W-1:0] acc);
    logic [ACC_W-1:0] s;
    s = acc_wsum5(acc_wsum5(acc));
    if (s >= 8'd5) s = s - 8'd5;
    if (s >= 8'd5) s = s - 8'd5;
    return 3'(s);
  endfunction

  logic [1:0] rem3_c;
  logic [2:0] rem5_c;

  logic       valid_q,    valid_d;
  logic       fizz_q,     fizz_d;
  logic       buzz_q,     buzz_d;
  logic       fizzbuzz_q, fizzbuzz_d;
  logic [1:0] rem3_q,     rem3_d;
  logic [2:0] rem5_q,     rem5_d;

  // Combinational residues of the incoming number.
  always_comb begin
    rem3_c = fold3(num_wsum3(number));
    rem5_c = fold5(num_wsum5(number));
  end

  // Next-state: load a fresh result on in_valid, otherwise hold the old one
  // (the mux keeps an undriven number out of the held registers).
  always_comb begin
    valid_d    = in_valid;
    fizz_d     = fizz_q;
    buzz_d     = buzz_q;
    fizzbuzz_d = fizzbuzz_q;
    rem3_d     = rem3_q;
    rem5_d     = rem5_q;
    if (in_valid) begin
      rem3_d     = rem3_c;
      rem5_d     = rem5_c;
      fizz_d     = (rem3_c == 2'd0);
      buzz_d     = (rem5_c == 3'd0);
      fizzbuzz_d = (rem3_c == 2'd0) && (rem5_c == 3'd0);
    end
  end

  // Result registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q    <= 1'b0;
      fizz_q     <= 1'b0;
      buzz_q     <= 1'b0;
      fizzbuzz_q <= 1'b0;
      rem3_q     <= 2'd0;
      rem5_q     <= 3'd0;
    end else begin
      valid_q    <= valid_d;
      fizz_q     <= fizz_d;
      buzz_q     <= buzz_d;
      fizzbuzz_q <= fizzbuzz_d;
      rem3_q     <= rem3_d;
      rem5_q     <= rem5_d;
    end
  end

  assign out_valid = valid_q;
  assign fizz      = fizz_q;
  assign buzz      = buzz_q;
  assign fizzbuzz  = fizzbuzz_q;
  assign rem3      = rem3_q;
  assign rem5      = rem5_q;

endmodule

// File: tb/tb_fizzbuzz_core.sv
// Testbench for fizzbuzz_core: WIDTH=8 and WIDTH=12 instances, results
// checked against a modulo-arithmetic reference model.
module tb_fizzbuzz_core;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic        in_valid8, in_valid12;
  logic [7:0]  number8;
  logic [11:0] number12;
  logic        out_valid8, fizz8, buzz8, fizzbuzz8;
  logic [1:0]  rem3_8;
  logic [2:0]  rem5_8;
  logic        out_valid12, fizz12, buzz12, fizzbuzz12;
  logic [1:0]  rem3_12;
  logic [2:0]  rem5_12;

  fizzbuzz_core #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .number(number8),
    .out_valid(out_valid8), .fizz(fizz8), .buzz(buzz8), .fizzbuzz(fizzbuzz8),
    .rem3(rem3_8), .rem5(rem5_8)
  );

  fizzbuzz_core #(.WIDTH(12)) dut12 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid12), .number(number12),
    .out_valid(out_valid12), .fizz(fizz12), .buzz(buzz12), .fizzbuzz(fizzbuzz12),
    .rem3(rem3_12), .rem5(rem5_12)
  );

  // ---------------- scoreboard ----------------
  // Packed result: {out_valid, fizz, buzz, fizzbuzz, rem3[1:0], rem5[2:0]}
  logic [8:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: plain modulo arithmetic.
  function automatic logic [8:0] model(input int unsigned n);
    int unsigned r3, r5;
    r3 = n % 3;
    r5 = n % 5;
    return {1'b1, (r3 == 0), (r5 == 0), ((n % 15) == 0), 2'(r3), 3'(r5)};
  endfunction

  function automatic logic [8:0] obs8();
    return {out_valid8, fizz8, buzz8, fizzbuzz8, rem3_8, rem5_8};
  endfunction

  function automatic logic [8:0] obs12();
    return {out_valid12, fizz12, buzz12, fizzbuzz12, rem3_12, rem5_12};
  endfunction

  // ---------------- drivers ----------------
  task automatic drive8(input logic v, input logic [7:0] n);
    @(negedge clk);
    in_valid8 = v;
    number8   = n;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [8:0] got;
    rst_n = 1'b1; in_valid8 = 1'b0; number8 = '0; in_valid12 = 1'b0; number12 = '0;
    #1 rst_n = 1'b0;
    #1;
    got = obs8();
    n_checks++;
    if (got !== 9'd0) begin
      n_fail++; $display("FAIL reset_initial got=%b exp=%b", got, 9'd0);
    end
    got = obs12();
    n_checks++;
    if (got !== 9'd0) begin
      n_fail++; $display("FAIL reset_initial12 got=%b exp=%b", got, 9'd0);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      n_checks++;
      if (out_valid8 !== 1'b0) begin
        n_fail++; $display("FAIL reset_idle out_valid got=%b exp=0", out_valid8);
      end
    end
  endtask

  task automatic test_reset_midstream();
    logic [8:0] got;
    drive8(1'b1, 8'd15);
    @(posedge clk); #1;
    got = obs8();
    n_checks++;
    if (got !== model(15)) begin
      n_fail++; $display("FAIL mid_reset_pre got=%b exp=%b", got, model(15));
    end
    #2 rst_n = 1'b0;  // mid-cycle, away from any clock edge
    #1;
    got = obs8();
    n_checks++;
    if (got !== 9'd0) begin
      n_fail++; $display("FAIL mid_reset_async got=%b exp=%b", got, 9'd0);
    end
    // in_valid still high across an edge while in reset: outputs stay 0
    @(posedge clk); #1;
    got = obs8();
    n_checks++;
    if (got !== 9'd0) begin
      n_fail++; $display("FAIL mid_reset_hold got=%b exp=%b", got, 9'd0);
    end
    @(negedge clk);
    in_valid8 = 1'b0;
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      n_checks++;
      if (out_valid8 !== 1'b0) begin
        n_fail++; $display("FAIL mid_reset_release out_valid got=%b exp=0", out_valid8);
      end
    end
  endtask

  task automatic test_sweep8();
    logic [8:0] got, exp;
    exp_q.delete();
    for (int n = 0; n <= 256; n++) begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        exp = exp_q.pop_front();
        got = obs8();
        n_checks++;
        if (got !== exp) begin
          n_fail++; $display("FAIL sweep8 n=%0d got=%b exp=%b", n - 1, got, exp);
        end
      end
      if (n < 256) begin
        in_valid8 = 1'b1;
        number8   = 8'(n);
        exp_q.push_back(model(n));
      end else begin
        in_valid8 = 1'b0;
      end
    end
  endtask

  // Hand-written expectations for the called-out values.
  task automatic test_spot_values();
    logic [7:0] vals [7] = '{8'd3, 8'd5, 8'd15, 8'd7, 8'd0, 8'd255, 8'd254};
    logic [8:0] exps [7] = '{
      {1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 3'd3},
      {1'b1, 1'b0, 1'b1, 1'b0, 2'd2, 3'd0},
      {1'b1, 1'b1, 1'b1, 1'b1, 2'd0, 3'd0},
      {1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 3'd2},
      {1'b1, 1'b1, 1'b1, 1'b1, 2'd0, 3'd0},
      {1'b1, 1'b1, 1'b1, 1'b1, 2'd0, 3'd0},
      {1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 3'd4}};
    logic [8:0] got;
    for (int k = 0; k < 7; k++) begin
      drive8(1'b1, vals[k]);
      @(negedge clk);
      got = obs8();
      n_checks++;
      if (got !== exps[k]) begin
        n_fail++; $display("FAIL spot n=%0d got=%b exp=%b", vals[k], got, exps[k]);
      end
      in_valid8 = 1'b0;
    end
  endtask

  task automatic test_hold();
    logic [8:0] got;
    logic [8:0] held = {1'b0, 1'b0, 1'b1, 1'b0, 2'd1, 3'd0};
    drive8(1'b1, 8'd10);
    @(negedge clk);
    got = obs8();
    n_checks++;
    if (got !== {1'b1, held[7:0]}) begin
      n_fail++; $display("FAIL hold_load got=%b exp=%b", got, {1'b1, held[7:0]});
    end
    in_valid8 = 1'b0;
    number8   = 'x;
    for (int c = 0; c < 3; c++) begin
      if (c == 2) number8 = 8'd9;
      @(negedge clk);
      got = obs8();
      n_checks++;
      if (got !== held) begin
        n_fail++; $display("FAIL hold_cycle%0d got=%b exp=%b", c, got, held);
      end
    end
  endtask

  task automatic test_gapped();
    logic [7:0] seq [3] = '{8'd6, 8'd25, 8'd30};
    logic [1:0] fb  [3] = '{2'b10, 2'b01, 2'b11};
    logic [8:0] got;
    for (int k = 0; k < 3; k++) begin
      drive8(1'b1, seq[k]);
      drive8(1'b0, 8'd0);  // result of seq[k] visible now
      got = obs8();
      n_checks++;
      if (got !== model(seq[k]) || got[7:6] !== fb[k]) begin
        n_fail++; $display("FAIL gapped_valid n=%0d got=%b exp=%b", seq[k], got, model(seq[k]));
      end
      @(negedge clk);
      n_checks++;
      if (out_valid8 !== 1'b0 || {fizz8, buzz8} !== fb[k]) begin
        n_fail++; $display("FAIL gapped_gap n=%0d got=%b%b%b exp=0%b", seq[k], out_valid8, fizz8, buzz8, fb[k]);
      end
    end
  endtask

  task automatic test_width12();
    logic [8:0] got, exp;
    int unsigned n;
    exp_q.delete();
    for (int k = 0; k <= 1002; k++) begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        exp = exp_q.pop_front();
        got = obs12();
        n_checks++;
        if (got !== exp) begin
          n_fail++; $display("FAIL width12 k=%0d got=%b exp=%b", k - 1, got, exp);
        end
      end
      if (k < 1002) begin
        if (k == 1000) n = 4095;
        else if (k == 1001) n = 0;
        else n = $urandom_range(0, 4095);
        if (k > 0 && $urandom_range(0, 7) == 0) begin
          in_valid12 = 1'b0;  // occasional bubble
          number12   = 12'($urandom);
          exp_q.push_back({1'b0, exp[7:0]});
          k--;
          continue;
        end
        in_valid12 = 1'b1;
        number12   = 12'(n);
        exp = model(n);
        exp_q.push_back(exp);
      end else begin
        in_valid12 = 1'b0;
      end
    end
    // 4095 = 3*1365 = 5*819
    n_checks++;
    if (model(4095) !== {1'b1, 1'b1, 1'b1, 1'b1, 2'd0, 3'd0}) begin
      n_fail++; $display("FAIL model_4095 got=%b", model(4095));
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_reset_midstream();
    test_sweep8();
    test_spot_values();
    test_hold();
    test_gapped();
    test_width12();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time limit so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout reached at %0t", $time);
    $fatal(1, "timeout");
  end

endmodule
